// File: rtl/draw_player_anim_if.sv
// Player state enum and the VGA stream bundle shared by the render chain.
// Each stage takes vga_if.in and drives vga_if.out.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } State;
endpackage

interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount, vsync, hsync,
    input vblnk, hblnk, rgb
  );
  modport out (
    output vcount, hcount, vsync, hsync,
    output vblnk, hblnk, rgb
  );
endinterface

// File: rtl/draw_player_anim.sv
// Animated player sprite overlay, 2-cycle pipeline, frame-latched pose.
// Optional 1-pixel outline when DRAW_PLAYER_OUTLINE_EN is defined.
module draw_player_anim
  import state_pkg::*;
#(
  parameter int W            = 40,
  parameter int BODY_H       = 60,
  parameter int LEG_H        = 20,
  parameter int Y_BASE       = 420,
  parameter int EYE_SIZE     = 6,
  parameter int STEP_FRAMES  = 8,
  parameter int BLINK_PERIOD = 120,
  parameter int BLINK_LEN    = 6,
  parameter logic [11:0] COLOR_BODY = 12'hFFF,
  parameter logic [11:0] COLOR_EYE  = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [11:0] xpos_player,
  input  logic [11:0] ypos_player,
  input  State        state
);
  localparam int H  = BODY_H + LEG_H;
  localparam int EL = W / 4 - EYE_SIZE / 2;
  localparam int ER = 3 * W / 4 - EYE_SIZE / 2;
  localparam int EY = 20;
  localparam int SW = $clog2(STEP_FRAMES + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);

  logic [11:0] x_l;
  logic [11:0] y_l;
  State        st_l;
  logic [SW-1:0] step_cnt;
  logic          phase;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic          vblnk_d;
  logic          tick;

  assign tick = vga_in.vblnk && !vblnk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d   <= 1'b0;
      x_l       <= '0;
      y_l       <= 12'(Y_BASE);
      st_l      <= IDLE;
      step_cnt  <= '0;
      phase     <= 1'b0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      vblnk_d <= vga_in.vblnk;
      if (tick) begin
        x_l  <= xpos_player;
        y_l  <= 12'(Y_BASE) + ypos_player;
        st_l <= state;
        if (state != st_l || st_l == IDLE) begin
          step_cnt <= '0;
          phase    <= 1'b0;
        end else if (step_cnt == SW'(STEP_FRAMES - 1)) begin
          step_cnt <= '0;
          phase    <= ~phase;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
        if (blink_cnt == BW'(BLINK_PERIOD - 1))
          blink_cnt <= '0;
        else
          blink_cnt <= blink_cnt + 1'b1;
        blink <= (blink_cnt < BW'(BLINK_LEN))
                 && (state == IDLE);
      end
    end
  end

  // Signed offsets keep off-screen parts clipped
  logic signed [12:0] rx;
  logic signed [12:0] ry;
  int   rxi;
  int   ryi;
  logic in_box;
`ifdef DRAW_PLAYER_OUTLINE_EN
  logic near;
`endif

  always_comb begin
    rx = $signed({2'b00, vga_in.hcount})
       - $signed({1'b0, x_l});
    ry = $signed({2'b00, vga_in.vcount})
       - $signed({1'b0, y_l});
    rxi = int'(rx);
    ryi = int'(ry);
    in_box = (rxi >= 0) && (rxi < W)
          && (ryi >= 0) && (ryi < H);
`ifdef DRAW_PLAYER_OUTLINE_EN
    near = (rxi >= -1) && (rxi <= W)
        && (ryi >= -1) && (ryi <= H);
`endif
  end

  logic [10:0] s1_v, s1_h;
  logic        s1_vs, s1_hs, s1_vb, s1_hb;
  logic [11:0] s1_rgb;
  logic signed [12:0] s1_rx, s1_ry;
  logic        s1_in_box;
  State        s1_st;
  logic        s1_phase;
  logic        s1_blink;
`ifdef DRAW_PLAYER_OUTLINE_EN
  logic        s1_near;
`endif

  // Pose travels with the pixel so a tick never splits it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= '0;
      s1_h      <= '0;
      s1_vs     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vb     <= 1'b0;
      s1_hb     <= 1'b0;
      s1_rgb    <= '0;
      s1_rx     <= '0;
      s1_ry     <= '0;
      s1_in_box <= 1'b0;
      s1_st     <= IDLE;
      s1_phase  <= 1'b0;
      s1_blink  <= 1'b0;
`ifdef DRAW_PLAYER_OUTLINE_EN
      s1_near   <= 1'b0;
`endif
    end else begin
      s1_v      <= vga_in.vcount;
      s1_h      <= vga_in.hcount;
      s1_vs     <= vga_in.vsync;
      s1_hs     <= vga_in.hsync;
      s1_vb     <= vga_in.vblnk;
      s1_hb     <= vga_in.hblnk;
      s1_rgb    <= vga_in.rgb;
      s1_rx     <= rx;
      s1_ry     <= ry;
      s1_in_box <= in_box;
      s1_st     <= st_l;
      s1_phase  <= phase;
      s1_blink  <= blink;
`ifdef DRAW_PLAYER_OUTLINE_EN
      s1_near   <= near;
`endif
    end
  end

  int   rx2;
  int   ry2;
  int   ax;
  logic eye_idle;
  logic leg0;
  logic leg1;
  logic [11:0] rgb_nx;

  always_comb begin
    rx2 = int'(s1_rx);
    ry2 = int'(s1_ry);
    ax  = (s1_st == LEFT) ? (W - 1 - rx2) : rx2;
    eye_idle = (ry2 >= EY) && (ry2 < EY + EYE_SIZE)
      && (((ax >= EL) && (ax < EL + EYE_SIZE))
       || ((ax >= ER) && (ax < ER + EYE_SIZE)));
    leg0 = (ry2 >= BODY_H)
      && ((ax < W * 3 / 8) || (ax >= W * 5 / 8));
    leg1 = (ry2 >= BODY_H)
      && (ax >= W / 2 - 8) && (ax < W / 2 + 8);
    rgb_nx = s1_rgb;
    if (s1_in_box) begin
      if (s1_st == IDLE) begin
        if (eye_idle)
          rgb_nx = s1_blink ? COLOR_BODY : COLOR_EYE;
        else if ((ry2 < BODY_H) || leg0)
          rgb_nx = COLOR_BODY;
      end else begin
        if ((ax < W - 15) && (ry2 < BODY_H))
          rgb_nx = COLOR_BODY;
        else if ((ax >= W - 15) && (ax < W - 10)
              && (ry2 >= 5) && (ry2 < 35))
          rgb_nx = COLOR_EYE;
        else if (s1_phase ? leg1 : leg0)
          rgb_nx = COLOR_BODY;
      end
    end
`ifdef DRAW_PLAYER_OUTLINE_EN
    else if (s1_near) begin
      rgb_nx = COLOR_EYE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_out.vcount <= '0;
      vga_out.hcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= s1_v;
      vga_out.hcount <= s1_h;
      vga_out.vsync  <= s1_vs;
      vga_out.hsync  <= s1_hs;
      vga_out.vblnk  <= s1_vb;
      vga_out.hblnk  <= s1_hb;
      vga_out.rgb    <= rgb_nx;
    end
  end
endmodule

// File: tb/tb_draw_player_anim.sv
// Bench for draw_player_anim: frame-level sprite model, per-cycle compare,
// plus literal probes of the documented pixels.
module tb_draw_player_anim;
  import state_pkg::*;

  localparam logic [11:0] BG = 12'h0F0;

  typedef struct packed {
    logic [10:0] v;
    logic [10:0] h;
    logic        vs;
    logic        hs;
    logic        vb;
    logic        hb;
    logic [11:0] rgb;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  State        st = IDLE;

  vga_if vin ();
  vga_if vout ();

  draw_player_anim dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_in      (vin),
    .vga_out     (vout),
    .xpos_player (xpos),
    .ypos_player (ypos),
    .state       (st)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h",
                  name, act, req);
  endtask

  // Sprite as a picture: plain rectangles in sprite coordinates.
  function automatic logic [11:0] sprite_px(
    input int rx, input int ry, input State s,
    input bit ph, input bit bl, input logic [11:0] bg);
    int mx;
    if (!(rx >= 0 && rx < 40 && ry >= 0 && ry < 80)) begin
`ifdef DRAW_PLAYER_OUTLINE_EN
      if (rx >= -1 && rx <= 40 && ry >= -1 && ry <= 80)
        return 12'h000;
`endif
      return bg;
    end
    if (s == IDLE) begin
      if (ry >= 20 && ry < 26 &&
          ((rx >= 7 && rx < 13) || (rx >= 27 && rx < 33)))
        return bl ? 12'hFFF : 12'h000;
      if (ry < 60) return 12'hFFF;
      if (rx < 15 || rx >= 25) return 12'hFFF;
      return bg;
    end
    mx = (s == LEFT) ? 39 - rx : rx;
    if (mx < 25 && ry < 60) return 12'hFFF;
    if (mx >= 25 && mx < 30 && ry >= 5 && ry < 35)
      return 12'h000;
    if (ry >= 60) begin
      if (ph ? (rx >= 12 && rx < 28) : (rx < 15 || rx >= 25))
        return 12'hFFF;
    end
    return bg;
  endfunction

  // Frame-level model: pose, ticks since reset, ticks in current walk
  logic [11:0] m_x, m_y;
  State        m_st;
  int          m_run;
  int          m_ticks;
  bit          m_blink;
  bit          m_vd;
  px_t         exp_now, exp_mid, exp_out;

  always_comb begin
    exp_now.v   = vin.vcount;
    exp_now.h   = vin.hcount;
    exp_now.vs  = vin.vsync;
    exp_now.hs  = vin.hsync;
    exp_now.vb  = vin.vblnk;
    exp_now.hb  = vin.hblnk;
    exp_now.rgb = sprite_px(int'(vin.hcount) - int'(m_x),
                            int'(vin.vcount) - int'(m_y),
                            m_st, ((m_run / 8) % 2) == 1,
                            m_blink, vin.rgb);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_mid <= '0;
      exp_out <= '0;
      m_x     <= '0;
      m_y     <= 12'd420;
      m_st    <= IDLE;
      m_run   <= 0;
      m_ticks <= 0;
      m_blink <= 1'b0;
      m_vd    <= 1'b0;
    end else begin
      exp_mid <= exp_now;
      exp_out <= exp_mid;
      m_vd    <= vin.vblnk;
      if (vin.vblnk && !m_vd) begin
        m_x     <= xpos;
        m_y     <= 12'd420 + ypos;
        m_st    <= st;
        m_run   <= (st != m_st || st == IDLE) ? 0 : m_run + 1;
        m_blink <= ((m_ticks % 120) < 6) && (st == IDLE);
        m_ticks <= m_ticks + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("stream", 64'({vout.vcount, vout.hcount,
            vout.vsync, vout.hsync, vout.vblnk,
            vout.hblnk, vout.rgb}), 64'(exp_out));
    end
  end

  task automatic set_px(input logic [10:0] h,
                        input logic [10:0] v,
                        input logic [11:0] c);
    vin.hcount = h;
    vin.vcount = v;
    vin.rgb    = c;
    vin.vblnk  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
  endtask

  task automatic probe(input logic [10:0] h,
                       input logic [10:0] v,
                       input logic [11:0] req,
                       input string name);
    @(posedge clk); #1;
    set_px(h, v, BG);
    @(posedge clk);
    @(posedge clk); #2;
    check(name, 64'(vout.rgb), 64'(req));
  endtask

  task automatic tick();
    @(posedge clk); #1;
    vin.vblnk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vin.vblnk = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("reset_out", 64'({vout.vcount, vout.hcount,
          vout.vsync, vout.hsync, vout.vblnk,
          vout.hblnk, vout.rgb}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: no finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [10:0] h, v;
    set_px(11'd0, 11'd0, BG);
    #1 rst_n = 1'b0;
    #3;
    check("reset_out", 64'({vout.vcount, vout.hcount,
          vout.vsync, vout.hsync, vout.vblnk,
          vout.hblnk, vout.rgb}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    probe(11'd5, 11'd430, 12'hFFF, "rst_body");
    probe(11'd10, 11'd441, 12'h000, "rst_eye");
    probe(11'd50, 11'd430, BG, "rst_bg");
    probe(11'd5, 11'd419, BG, "rst_above");

    // Blink: tick k since reset closes eyes for k%120 < 6
    xpos = 12'd100;
    for (int k = 0; k < 124; k++) begin
      tick();
      probe(11'd110, 11'd441,
            ((k % 120) < 6) ? 12'hFFF : 12'h000, "blink_eye");
      if (k == 10) begin
        probe(11'd120, 11'd430, 12'hFFF, "idle_body");
        probe(11'd120, 11'd490, BG, "idle_leg_gap");
        probe(11'd103, 11'd490, 12'hFFF, "idle_leg");
`ifdef DRAW_PLAYER_OUTLINE_EN
        probe(11'd99, 11'd430, 12'h000, "outline");
`else
        probe(11'd99, 11'd430, BG, "no_outline");
`endif
      end
    end

    // Walk phases
    st = RIGHT;
    xpos = 12'd200;
    for (int k = 0; k < 17; k++) begin
      tick();
      probe(11'd203, 11'd490,
            (((k / 8) % 2) == 0) ? 12'hFFF : BG, "walk_leg");
    end
    probe(11'd227, 11'd450, 12'h000, "right_eye");

    // Mid-frame position change waits for the next tick
    st = IDLE;
    xpos = 12'd100;
    tick();
    probe(11'd120, 11'd430, 12'hFFF, "pos_old");
    xpos = 12'd300;
    probe(11'd120, 11'd430, 12'hFFF, "pos_held");
    probe(11'd320, 11'd430, BG, "pos_not_yet");
    tick();
    probe(11'd320, 11'd430, 12'hFFF, "pos_new");
    probe(11'd120, 11'd430, BG, "pos_old_gone");

    // Right-edge clipping
    xpos = 12'd1010;
    tick();
    probe(11'd1015, 11'd430, 12'hFFF, "clip_in");
    probe(11'd0, 11'd430, BG, "clip_h0");
    probe(11'd25, 11'd430, BG, "clip_h25");

    // Randomized frames
    for (int f = 0; f < 180; f++) begin
      if ($urandom_range(0, 11) == 0)
        st = State'(2'($urandom_range(0, 2)));
      xpos = ($urandom_range(0, 7) == 0) ? 12'($urandom)
           : 12'($urandom_range(0, 1100));
      ypos = ($urandom_range(0, 7) == 0) ? 12'($urandom)
           : 12'($urandom_range(0, 200));
      tick();
      if (f == 90) begin
        do_reset();
        probe(11'd5, 11'd430, 12'hFFF, "rst2_body");
      end
      for (int p = 0; p < 30; p++) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) begin
          h = 11'($urandom);
          v = 11'($urandom);
        end else begin
          h = 11'(int'(xpos) + $urandom_range(0, 45) - 3);
          v = 11'(420 + int'(ypos) + $urandom_range(0, 85) - 3);
        end
        set_px(h, v, 12'($urandom));
        vin.hsync = 1'($urandom);
        vin.vsync = 1'($urandom);
        vin.hblnk = 1'($urandom);
        vin.vblnk = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 15) == 0)
          xpos = 12'($urandom_range(0, 1100));
      end
    end

    @(posedge clk); #1;
    set_px(11'd0, 11'd0, BG);
    repeat (4) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
